resolve_quadratic: RTL and testbench
====================================

Name: resolve_quadratic

Overview:
Multi-cycle evaluator of the quadratic y = A*x^2 + B*x + C on signed two's-complement operands. A single start strobe launches the computation. The block sequences one multiply or add per clock through a small FSM and presents the result with ready/valid status flags. It sits as a co-processor next to a controller that supplies the coefficients and polls ready/valid.

Parameters:
XW, 8, width of signed input x
DW, 16, width of signed coefficients a, b, c and of result y

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
inicio  input  1  start request, sampled on rising clk while ready=1
x  input  XW  signed variable x
a  input  DW  signed coefficient A
b  input  DW  signed coefficient B
c  input  DW  signed constant C
y  output  DW  signed result, registered
ready  output  1  1 = idle, able to accept inicio
valid  output  1  1 = y holds the result of the last completed computation

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, y=0, valid=0, ready=1, internal registers=0. Reset during any state aborts the computation with no partial result.
- Arithmetic: x is sign-extended to DW bits. Every product and sum is truncated to DW bits, with two's-complement wrap and no saturation or overflow flag.
- States and transitions (one per clock):
  - IDLE: ready=1. If inicio=1, latch x, a, b, c into internal registers, clear valid, set ready=0, go to SQ. Otherwise stay, holding y and valid.
  - SQ: t1 <= x*x; go to AX2.
  - AX2: acc <= a*t1; go to BX.
  - BX: t2 <= b*x; go to SUM1.
  - SUM1: acc <= acc + t2; go to SUM2.
  - SUM2: y <= acc + c_latched; valid <= 1; ready <= 1; go to IDLE.
- Latency: inicio accepted at edge N means y is updated and valid=1 after edge N+5. ready is 0 from after edge N through edge N+4 inclusive.
- valid stays 1 and y holds until the next accepted inicio clears valid, or until reset.
- Changes on x, a, b, c or inicio while busy are ignored; the latched operands are used.
- If inicio is held high continuously, a new computation is accepted on the first edge back in IDLE. Each run occupies 6 cycles, including 1 IDLE cycle.
- No illegal states are reachable. Encoding of unused states falls back to IDLE.

Test Plan:
- Reset then start: rst=0 for 1 cycle, then rst=1; x=1, a=2, b=3, c=4, pulse inicio -> ready drops, y=9 and valid=1 after 5 edges, ready=1.
- Signed operands: x=-3, a=1, b=2, c=-5 -> y=-2 (0xFFFE), valid=1.
- Wrap-around: x=127, a=16, b=0, c=0 -> y=-4080 (0xF010). x=-128, a=2, b=0, c=0 -> y=-32768 (0x8000).
- Inputs changed mid-run: start with x=2, a=1, b=1, c=1; change x to 5 on the next cycle -> y=7, not 31.
- inicio held high: x=1, a=2, b=3, c=4, then x=2 after the first acceptance -> y=9, valid then drops on re-acceptance, next y=18, each run 6 cycles apart.
- Asynchronous reset mid-run: assert rst=0 in state BX, between clock edges -> y=0, valid=0, ready=1 immediately; a subsequent start computes correctly.

Source files
------------

// File: rtl/resolve_quadratic.sv
// Multi-cycle evaluator of y = a*x^2 + b*x + c on signed operands.
// It shares one multiplier and one adder, stepping one operation per clock.
module resolve_quadratic #(
    parameter int XW = 8,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic signed [XW-1:0] x,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] c,
    output logic signed [DW-1:0] y,
    output logic                 ready,
    output logic                 valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SQ   = 3'd1;
    localparam logic [2:0] S_AX2  = 3'd2;
    localparam logic [2:0] S_BX   = 3'd3;
    localparam logic [2:0] S_SUM1 = 3'd4;
    localparam logic [2:0] S_SUM2 = 3'd5;

    logic [2:0]           state_r;
    logic signed [DW-1:0] x_r, a_r, b_r, c_r;
    logic signed [DW-1:0] t1_r, t2_r, acc_r, y_r;
    logic                 ready_r, valid_r;

    logic signed [DW-1:0] x_ext_s;
    logic signed [DW-1:0] mul_a_s, mul_b_s, mul_p_s;
    logic signed [DW-1:0] add_b_s, add_s;

    assign x_ext_s = {{(DW-XW){x[XW-1]}}, x};

    // Operand steering for the shared multiplier and adder; results wrap at DW bits
    always_comb begin
        mul_a_s = x_r;
        mul_b_s = x_r;
        add_b_s = t2_r;
        case (state_r)
            S_AX2: begin
                mul_a_s = a_r;
                mul_b_s = t1_r;
            end
            S_BX: begin
                mul_a_s = b_r;
                mul_b_s = x_r;
            end
            S_SUM2: begin
                add_b_s = c_r;
            end
            default: begin
                mul_a_s = x_r;
                mul_b_s = x_r;
                add_b_s = t2_r;
            end
        endcase
        mul_p_s = mul_a_s * mul_b_s;
        add_s   = acc_r + add_b_s;
    end

    // Sequencer: operand capture, intermediate results and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            x_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            t1_r    <= '0;
            t2_r    <= '0;
            acc_r   <= '0;
            y_r     <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (inicio) begin
                        x_r     <= x_ext_s;
                        a_r     <= a;
                        b_r     <= b;
                        c_r     <= c;
                        valid_r <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= S_SQ;
                    end
                end
                S_SQ: begin
                    t1_r    <= mul_p_s;
                    state_r <= S_AX2;
                end
                S_AX2: begin
                    acc_r   <= mul_p_s;
                    state_r <= S_BX;
                end
                S_BX: begin
                    t2_r    <= mul_p_s;
                    state_r <= S_SUM1;
                end
                S_SUM1: begin
                    acc_r   <= add_s;
                    state_r <= S_SUM2;
                end
                S_SUM2: begin
                    y_r     <= add_s;
                    valid_r <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign y     = y_r;
    assign ready = ready_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_resolve_quadratic.sv
// Self-checking bench for resolve_quadratic: directed cases from the test plan
// plus randomized operands compared against a plain-arithmetic reference.
module tb_resolve_quadratic;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inicio = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [15:0] a = 16'd0, b = 16'd0, c = 16'd0;
    logic [15:0] y;
    logic        ready, valid;

    int checks = 0;
    int failures = 0;

    resolve_quadratic #(.XW(8), .DW(16)) dut (
        .clk(clk), .rst(rst), .inicio(inicio),
        .x(x), .a(a), .b(b), .c(c),
        .y(y), .ready(ready), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact integer polynomial, then keep the low 16 bits
    function automatic logic [15:0] model(input logic [7:0] xv, input logic [15:0] av,
                                          input logic [15:0] bv, input logic [15:0] cv);
        int xi, r;
        xi = int'($signed(xv));
        r  = int'($signed(av)) * xi * xi + int'($signed(bv)) * xi + int'($signed(cv));
        return r[15:0];
    endfunction

    // Apply operands with a one-cycle inicio pulse; returns just after the negedge following acceptance
    task automatic start_run(input logic [7:0] xv, input logic [15:0] av,
                             input logic [15:0] bv, input logic [15:0] cv);
        @(negedge clk);
        x = xv; a = av; b = bv; c = cv;
        inicio = 1'b1;
        @(posedge clk); #1;
        check_eq("busy_after_start", {31'd0, ready}, 32'd0);
        check_eq("valid_cleared", {31'd0, valid}, 32'd0);
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp);
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_busy_n4"}, {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check_eq({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check_eq({tag, "_y"}, {16'd0, y}, {16'd0, exp});
    endtask

    initial begin
        logic [7:0]  rx;
        logic [15:0] ra, rb, rc;

        // Reset held across a clock edge
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_y", {16'd0, y}, 32'd0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        start_run(8'd1, 16'd2, 16'd3, 16'd4);
        wait_result("basic", 16'd9);

        start_run(8'hFD, 16'd1, 16'd2, 16'hFFFB);
        wait_result("signed", 16'hFFFE);

        start_run(8'd127, 16'd16, 16'd0, 16'd0);
        wait_result("wrap_pos", 16'hF010);

        start_run(8'h80, 16'd2, 16'd0, 16'd0);
        wait_result("wrap_neg", 16'h8000);

        // Result holds while idle even as inputs wander
        x = 8'd33; a = 16'd7; b = 16'd9; c = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_y", {16'd0, y}, 32'h0000_8000);
        check_eq("hold_valid", {31'd0, valid}, 32'd1);

        // Operand changes while busy are ignored
        start_run(8'd2, 16'd1, 16'd1, 16'd1);
        x = 8'd5; a = 16'd3; b = 16'd3; c = 16'd3;
        wait_result("midrun", 16'd7);

        // inicio held high: back-to-back runs six cycles apart
        @(negedge clk);
        x = 8'd1; a = 16'd2; b = 16'd3; c = 16'd4;
        inicio = 1'b1;
        @(posedge clk); #1;
        check_eq("held_busy", {31'd0, ready}, 32'd0);
        @(negedge clk);
        x = 8'd2;
        wait_result("held1", 16'd9);
        @(posedge clk); #1;
        check_eq("held_reaccept_valid", {31'd0, valid}, 32'd0);
        check_eq("held_reaccept_ready", {31'd0, ready}, 32'd0);
        wait_result("held2", 16'd18);
        @(negedge clk);
        inicio = 1'b0;

        // Asynchronous reset between edges while in BX
        start_run(8'd3, 16'd4, 16'd5, 16'd6);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_y", {16'd0, y}, 32'd0);
        check_eq("arst_valid", {31'd0, valid}, 32'd0);
        check_eq("arst_ready", {31'd0, ready}, 32'd1);
        #1;
        rst = 1'b1;
        start_run(8'd3, 16'd4, 16'd5, 16'd6);
        wait_result("after_arst", model(8'd3, 16'd4, 16'd5, 16'd6));

        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 16'($urandom);
            start_run(rx, ra, rb, rc);
            x = 8'($urandom); a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
            wait_result("rand", model(rx, ra, rb, rc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
